// File: rtl/ram_1r1w_be_init.sv
// Simple-dual-port RAM with per-lane write enables, optional read-during-write
// forwarding, a read-valid flag and a post-reset clear sequencer.
module ram_1r1w_be_init #(
  parameter int          AW       = 7,
  parameter int          DW       = 24,
  parameter int          LW       = 8,
  parameter int          BYPASS   = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW-1:0]      raddr,
  input  logic               re,
  output logic [DW-1:0]      rd,
  output logic               rvalid,
  input  logic [AW-1:0]      waddr,
  input  logic [DW-1:0]      wr,
  input  logic [DW/LW-1:0]   wbe,
  input  logic               we,
  output logic               init_busy
);

  localparam int            DEPTH = 1 << AW;
  localparam int            NL    = DW / LW;
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {CLEAR, IDLE} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mem [DEPTH];
  logic [DW-1:0]   rd_q, rd_d;
  logic            rvalid_q;
  logic            clr_en, usr_en;

  // Replace the lanes selected by be with the corresponding lanes of new_w.
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                               input logic [DW-1:0] new_w,
                                               input logic [NL-1:0] be);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NL; i++) begin
      if (be[i]) res[i*LW +: LW] = new_w[i*LW +: LW];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops on the LAST compare, so it never re-enters CLEAR by wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LAST) state_d = IDLE;
    end
  end

  always_comb begin
    clr_en    = (state_q == CLEAR);
    usr_en    = (state_q == IDLE);
    init_busy = (state_q == CLEAR);
  end

  // Memory array carries no reset; a reset cycle performs no write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_en) begin
        mem[cnt_q] <= INIT_VAL;
      end else if (usr_en && we) begin
        mem[waddr] <= lane_merge(mem[waddr], wr, wbe);
      end
    end
  end

  always_comb begin
    rd_d = mem[raddr];
    if (BYPASS != 0 && we && (raddr == waddr)) begin
      rd_d = lane_merge(mem[raddr], wr, wbe);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= usr_en && re;
      if (usr_en && re) rd_q <= rd_d;
    end
  end

  assign rd     = rd_q;
  assign rvalid = rvalid_q;

endmodule

// File: tb/tb_ram_1r1w_be_init.sv
// Bench for ram_1r1w_be_init: forwarding and non-forwarding instances share
// stimulus and are compared against an array-based reference model.
module tb_ram_1r1w_be_init;
  localparam int AW    = 7;
  localparam int DW    = 24;
  localparam int LW    = 8;
  localparam int NL    = DW / LW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, re, we;
  logic [AW-1:0] raddr, waddr;
  logic [DW-1:0] wr;
  logic [NL-1:0] wbe;
  logic [DW-1:0] rd_b1, rd_b0;
  logic          rv_b1, rv_b0, busy_b1, busy_b0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd1 = '0, m_rd0 = '0;
  logic          m_rv = 1'b0, m_busy = 1'b1;
  int            m_left = 0;

  always #5 clk = ~clk;

  ram_1r1w_be_init #(.AW(AW), .DW(DW), .LW(LW), .BYPASS(1), .INIT_VAL('0)) u_byp (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re), .rd(rd_b1), .rvalid(rv_b1),
    .waddr(waddr), .wr(wr), .wbe(wbe), .we(we), .init_busy(busy_b1));

  ram_1r1w_be_init #(.AW(AW), .DW(DW), .LW(LW), .BYPASS(0), .INIT_VAL('0)) u_nbyp (
    .clk(clk), .rst(rst), .raddr(raddr), .re(re), .rd(rd_b0), .rvalid(rv_b0),
    .waddr(waddr), .wr(wr), .wbe(wbe), .we(we), .init_busy(busy_b0));

  function automatic logic [DW-1:0] apply_lanes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NL-1:0] be);
    logic [DW-1:0] mask;
    logic [DW-1:0] ones;
    mask = '0;
    ones = DW'((1 << LW) - 1);
    for (int i = 0; i < NL; i++) begin
      if (be[i]) mask = mask | (ones << (i * LW));
    end
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    re = 1'b0; we = 1'b0; wbe = '0; wr = '0; raddr = '0; waddr = '0;
  endtask

  // Advance one clock: update the model with the current inputs, then compare.
  task automatic tick();
    logic [DW-1:0] old_w;
    if (rst) begin
      m_busy = 1'b1; m_left = DEPTH; m_rd1 = '0; m_rd0 = '0; m_rv = 1'b0;
    end else if (m_busy) begin
      m_rv = 1'b0;
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      old_w = m_mem[raddr];
      m_rv  = re;
      if (re) begin
        m_rd0 = old_w;
        m_rd1 = (we && raddr == waddr) ? apply_lanes(old_w, wr, wbe) : old_w;
      end
      if (we) m_mem[waddr] = apply_lanes(m_mem[waddr], wr, wbe);
    end
    @(posedge clk); #1;
    chk("busy_byp",  32'(busy_b1), 32'(m_busy));
    chk("busy_nbyp", 32'(busy_b0), 32'(m_busy));
    chk("rv_byp",    32'(rv_b1),   32'(m_rv));
    chk("rv_nbyp",   32'(rv_b0),   32'(m_rv));
    chk("rd_byp",    32'(rd_b1),   32'(m_rd1));
    chk("rd_nbyp",   32'(rd_b0),   32'(m_rd0));
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    idle_in(); we = 1'b1; waddr = a; wr = d; wbe = be;
    tick();
    idle_in();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    idle_in(); re = 1'b1; raddr = a;
    tick();
    idle_in();
  endtask

  // Count cycles with init_busy high; bounded so a stuck sequencer still ends.
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    while (busy_b1 && n < 200) begin
      n++;
      tick();
    end
    chk(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("reset_rd", 32'(rd_b1), 32'h0);
    chk("reset_busy", 32'(busy_b0), 32'h1);
    rst = 1'b0;

    // Clear with a request injected at cycle 10.
    begin
      int n;
      n = 0;
      while (busy_b1 && n < 200) begin
        if (n == 10) begin
          we = 1'b1; waddr = 7'd5; wr = 24'hABCDEF; wbe = '1; re = 1'b1; raddr = 7'd5;
        end else begin
          idle_in();
        end
        n++;
        tick();
        if (n == 11) begin
          chk("clr_req_rv", 32'(rv_b1), 32'h0);
          chk("clr_req_rd", 32'(rd_b1), 32'h0);
        end
      end
      idle_in();
      chk("clear_len", 32'(n), 32'(DEPTH));
    end

    for (int a = 0; a < DEPTH; a++) begin
      do_read(AW'(a));
      if (a == 5) chk("addr5_after_clr", 32'(rd_b1), 32'h0);
    end

    do_write(7'd9, 24'h112233, 3'b111);
    do_write(7'd9, 24'hAABBCC, 3'b010);
    do_read(7'd9);
    chk("lane_merge", 32'(rd_b1), 32'h11BB33);

    do_write(7'd20, 24'h000001, 3'b111);
    idle_in(); we = 1'b1; waddr = 7'd20; wr = 24'hFFFFFF; wbe = 3'b001; re = 1'b1; raddr = 7'd20;
    tick();
    idle_in();
    chk("rdw_byp",  32'(rd_b1), 32'h0000FF);
    chk("rdw_nbyp", 32'(rd_b0), 32'h000001);
    do_read(7'd20);
    chk("rdw_after_byp",  32'(rd_b1), 32'h0000FF);
    chk("rdw_after_nbyp", 32'(rd_b0), 32'h0000FF);

    do_write(7'd30, 24'h5A5A5A, 3'b000);
    do_read(7'd30);
    chk("wbe_zero_noop", 32'(rd_b1), 32'h0);

    do_read(7'd9);
    chk("hold_first_rv", 32'(rv_b1), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_rd", 32'(rd_b1), 32'h11BB33);
      chk("hold_rv", 32'(rv_b1), 32'h0);
    end

    // Random traffic on a narrow address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      re    = 1'($urandom_range(0, 1));
      we    = 1'($urandom_range(0, 1));
      raddr = AW'($urandom_range(0, 7));
      waddr = AW'($urandom_range(0, 7));
      wr    = DW'($urandom);
      wbe   = NL'($urandom);
      tick();
    end
    idle_in();

    do_write(7'd100, 24'h123456, 3'b111);
    do_read(7'd100);
    chk("pre_clear_100", 32'(rd_b1), 32'h123456);
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    rst = 1'b1; tick();
    chk("midclr_rd",   32'(rd_b1), 32'h0);
    chk("midclr_rv",   32'(rv_b0), 32'h0);
    chk("midclr_busy", 32'(busy_b1), 32'h1);
    rst = 1'b0;
    run_clear("reclear_len");
    do_read(7'd100);
    chk("addr100_cleared", 32'(rd_b1), 32'h0);
    chk("addr100_rv", 32'(rv_b1), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
